// File: rtl/idprom_reader.sv
// Boot-time sequencer for a 32x8 tri-state ID PROM. It latches the 16 defined bytes,
// checks the format byte and the XOR checksum, and presents the decoded fields.
module idprom_reader #(
    parameter int unsigned WAIT_CYCLES = 2,     // PROM access time in clocks, 0..15
    parameter logic [7:0]  FORMAT_ID   = 8'h01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [4:0]  prom_a,
    output logic        prom_s_n,
    input  logic [7:0]  prom_q,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        fmt_err,
    output logic        chk_err,
    output logic [7:0]  machine_type,
    output logic [47:0] eth_addr,
    output logic [31:0] date,
    output logic [23:0] serial,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic [3:0]  index;
    logic [3:0]  wait_cnt;
    logic [7:0]  acc;
    logic [7:0]  store [16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Select and busy decode straight from the state register, so an asynchronous
    // reset releases the PROM bus without waiting for a clock.
    always_comb begin
        // NOTE: every output of this block gets a default first; a missing branch would infer a latch.
        state_nx = state;
        accept   = 1'b0;
        prom_s_n = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                prom_s_n = 1'b0;
                busy     = 1'b1;
                state_nx = HAS_WAIT ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                prom_s_n = 1'b0;
                busy     = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                prom_s_n = 1'b0;
                busy     = 1'b1;
                state_nx = (index == 4'd15) ? S_CHECK : S_SETUP;
            end
            S_CHECK: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: the byte store is reset on purpose so every field and rd_data read zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index    <= 4'd0;
            wait_cnt <= 4'd0;
            acc      <= 8'd0;
            fmt_err  <= 1'b0;
            chk_err  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                store[i] <= 8'd0;
            end
        end else begin
            if (accept) begin
                index   <= 4'd0;
                acc     <= 8'd0;
                fmt_err <= 1'b0;
                chk_err <= 1'b0;
            end
            if (state == S_SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_CAPTURE) begin
                store[index] <= prom_q;
                // Byte 15 is the checksum itself and stays out of the accumulator.
                if (index != 4'd15) begin
                    acc   <= acc ^ prom_q;
                    index <= index + 4'd1;
                end
            end
            if (state == S_CHECK) begin
                fmt_err <= (store[0] != FORMAT_ID);
                chk_err <= (acc != store[15]);
            end
        end
    end

    // Index only advances at the CAPTURE->SETUP edge, so the address is stable in each window.
    assign prom_a       = {1'b0, index};
    assign valid        = done & ~fmt_err & ~chk_err;
    assign machine_type = store[1];
    assign eth_addr     = {store[2], store[3], store[4], store[5], store[6], store[7]};
    assign date         = {store[8], store[9], store[10], store[11]};
    assign serial       = {store[12], store[13], store[14]};
    assign rd_data      = store[rd_addr];

endmodule

// File: tb/tb_idprom_reader.sv
// Scoreboard bench for idprom_reader: three instances (WAIT_CYCLES 2, 0, 5) share a PROM
// model; one monitor checks bus windows and pops expected results on each rising done.
`timescale 1ns/1ps
module tb_idprom_reader;

    localparam int N = 3;

    function automatic int wsel(int g);
        case (g)
            0:       return 2;
            1:       return 0;
            default: return 5;
        endcase
    endfunction

    typedef struct {
        int          inst;
        int          done_cyc;
        logic [7:0]  mt;
        logic [47:0] eth;
        logic [31:0] date;
        logic [23:0] serial;
        logic [7:0]  rdd;
        logic        fmt;
        logic        chk;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [3:0]  rd_addr = '0;
    logic [4:0]  prom_a_v [N];
    logic [2:0]  prom_s_n_v, busy_v, done_v, valid_v, fmt_v, chk_v;
    logic [7:0]  mt_v [N];
    logic [47:0] eth_v [N];
    logic [31:0] date_v [N];
    logic [23:0] ser_v [N];
    logic [7:0]  rdd_v [N];
    logic [7:0]  prom_mem [32];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wire [7:0] q;
        assign q = prom_s_n_v[g] ? 8'hzz : prom_mem[prom_a_v[g]];
        idprom_reader #(.WAIT_CYCLES(wsel(g)), .FORMAT_ID(8'h01)) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start_v[g]),
            .prom_a(prom_a_v[g]), .prom_s_n(prom_s_n_v[g]), .prom_q(q),
            .busy(busy_v[g]), .done(done_v[g]), .valid(valid_v[g]),
            .fmt_err(fmt_v[g]), .chk_err(chk_v[g]),
            .machine_type(mt_v[g]), .eth_addr(eth_v[g]), .date(date_v[g]),
            .serial(ser_v[g]), .rd_addr(rd_addr), .rd_data(rdd_v[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_default();
        logic [7:0] dflt [16];
        dflt = '{8'h01, 8'h01, 8'h08, 8'h00, 8'h20, 8'h01, 8'h06, 8'hE0,
                 8'h1A, 8'hE4, 8'h23, 8'h3B, 8'h00, 8'h0D, 8'h72, 8'h56};
        for (int i = 0; i < 32; i++) prom_mem[i] = (i < 16) ? dflt[i] : 8'hFF;
    endtask

    function automatic exp_t mk(logic [7:0] mt, logic [47:0] eth, logic [31:0] date,
                                logic [23:0] serial, logic [7:0] rdd,
                                logic fmt, logic chk, logic valid);
        exp_t e;
        e.inst = 0; e.done_cyc = 0;
        e.mt = mt; e.eth = eth; e.date = date; e.serial = serial; e.rdd = rdd;
        e.fmt = fmt; e.chk = chk; e.valid = valid;
        return e;
    endfunction

    task automatic start_pulse(input int i, output int k);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done_v[i] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_v[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: inst %0d done=0 after %0d cycles, expected 1", i, budget);
        end
        @(negedge clk);
        #1;
    endtask

    // Issue a full read on instance i; restart_at >= 0 fires a second start that many
    // edges after the accepted one, which must be ignored.
    task automatic run(input int i, input exp_t e_in, input int restart_at);
        exp_t e;
        int   k;
        e = e_in;
        start_pulse(i, k);
        e.inst     = i;
        e.done_cyc = k + 16 * (wsel(i) + 2) + 1;
        sb_q.push_back(e);
        if (restart_at >= 0) begin
            while (cyc < k + restart_at) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            start_v[i] = 1'b1;
            @(posedge clk);
            #1;
            start_v[i] = 1'b0;
            check("restart_busy", busy_v[i], 1'b1);
            check("restart_addr", prom_a_v[i], 5'd7);
        end
        wait_done(i, 300);
    endtask

    // Bus-protocol and scoreboard monitor, sampling on the falling edge.
    initial begin
        int         run_len [N];
        logic [4:0] run_addr [N];
        logic [3:0] exp_addr [N];
        logic [2:0] done_q;
        exp_t       e;
        done_q = '0;
        for (int i = 0; i < N; i++) begin
            run_len[i] = 0; run_addr[i] = '0; exp_addr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!reset_n) begin
                    run_len[i]  = 0;
                    exp_addr[i] = '0;
                    done_q[i]   = 1'b0;
                end else begin
                    if (run_len[i] > 0 && (prom_s_n_v[i] || prom_a_v[i] != run_addr[i])) begin
                        check("win_len", run_len[i], wsel(i) + 2);
                        check("win_addr", run_addr[i], {1'b0, exp_addr[i]});
                        exp_addr[i] = exp_addr[i] + 4'd1;
                        run_len[i]  = 0;
                    end
                    if (!prom_s_n_v[i]) begin
                        if (run_len[i] == 0) begin
                            run_addr[i] = prom_a_v[i];
                            check("bus_a4", prom_a_v[i][4], 1'b0);
                        end
                        run_len[i]++;
                    end
                    if (done_v[i] && !done_q[i]) begin
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL sb_unexpected: inst %0d raised done with no read pending", i);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_inst", i, e.inst);
                            check("sb_done_cyc", cyc, e.done_cyc);
                            check("sb_valid", valid_v[i], e.valid);
                            check("sb_fmt_err", fmt_v[i], e.fmt);
                            check("sb_chk_err", chk_v[i], e.chk);
                            check("sb_busy", busy_v[i], 1'b0);
                            check("sb_machine_type", mt_v[i], e.mt);
                            check("sb_eth_addr", eth_v[i], e.eth);
                            check("sb_date", date_v[i], e.date);
                            check("sb_serial", ser_v[i], e.serial);
                            check("sb_rd_data", rdd_v[i], e.rdd);
                        end
                    end
                    done_q[i] = done_v[i];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t good;
        int   k;
        load_default();
        good = mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h000D72, 8'h56, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_prom_s_n", prom_s_n_v, 3'b111);
        check("rst_prom_a", prom_a_v[0], 5'd0);
        check("rst_busy", busy_v, 3'b000);
        check("rst_done", done_v, 3'b000);
        check("rst_valid", valid_v, 3'b000);
        check("rst_errs", {fmt_v, chk_v}, 6'd0);
        check("rst_rd_data", rdd_v[0], 8'h00);

        rd_addr = 4'hF;
        run(0, good, -1);
        repeat (5) @(posedge clk);
        #1;
        check("done_held", done_v[0], 1'b1);
        check("valid_held", valid_v[0], 1'b1);

        run(0, good, 29);

        prom_mem[15] = 8'h57;
        run(0, mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h000D72, 8'h57,
                  1'b0, 1'b1, 1'b0), -1);

        prom_mem[0]  = 8'h02;
        prom_mem[15] = 8'h55;
        rd_addr      = 4'h0;
        run(0, mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h000D72, 8'h02,
                  1'b1, 1'b0, 1'b0), -1);

        load_default();
        rd_addr = 4'h7;
        run(1, mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h000D72, 8'hE0,
                  1'b0, 1'b0, 1'b1), -1);

        prom_mem[12] = 8'h12;
        prom_mem[13] = 8'h34;
        prom_mem[14] = 8'h56;
        prom_mem[15] = 8'h59;
        rd_addr      = 4'hC;
        run(2, mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h123456, 8'h12,
                  1'b0, 1'b0, 1'b1), -1);

        // Asynchronous reset in the middle of byte 9's wait window.
        load_default();
        rd_addr = 4'h9;
        start_pulse(0, k);
        while (cyc < k + 37) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_addr", prom_a_v[0], 5'd9);
        check("pre_rst_s_n", prom_s_n_v[0], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_prom_s_n", prom_s_n_v[0], 1'b1);
        check("arst_prom_a", prom_a_v[0], 5'd0);
        check("arst_busy", busy_v[0], 1'b0);
        check("arst_done_valid", {done_v[0], valid_v[0]}, 2'b00);
        check("arst_machine_type", mt_v[0], 8'h00);
        check("arst_eth_addr", eth_v[0], 48'h0);
        check("arst_date", date_v[0], 32'h0);
        check("arst_serial", ser_v[0], 24'h0);
        check("arst_rd_data", rdd_v[0], 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run(0, mk(8'h01, 48'h0800_2001_06E0, 32'h1AE4_233B, 24'h000D72, 8'hE4,
                  1'b0, 1'b0, 1'b1), -1);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idprom_reader.md
Name: idprom_reader

Overview:
- Sequencer that reads the 32x8 ID PROM (74S288-style, tri-state, active-low select) at boot and latches the 16 defined bytes into local registers.
- Validates the format byte and the XOR checksum.
- Presents machine type, Ethernet MAC, date and serial number to the rest of the design.
- Provides a random-access byte port so CPU-side logic does not need to touch the PROM bus.

Parameters:
- WAIT_CYCLES, 2, clocks between address/select valid and data capture (PROM access time); legal range 0..15.
- FORMAT_ID, 8'h01, required value of byte 0x00.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a full read. Ignored unless FSM is in IDLE or DONE.
- prom_a  out  5  PROM address A4..A0.
- prom_s_n  out  1  PROM select S0_n; low only during a byte read window.
- prom_q  in  8  PROM data Q7..Q0; tri-stated (z) while prom_s_n is high.
- busy  out  1  read sequence in progress.
- done  out  1  sequence complete; held until the next start or reset.
- valid  out  1  done, with format and checksum both good.
- fmt_err  out  1  byte 0x00 != FORMAT_ID.
- chk_err  out  1  XOR of bytes 0x00..0x0E != byte 0x0F.
- machine_type  out  8  byte 0x01.
- eth_addr  out  48  bytes 0x02..0x07; byte 0x02 is the MSB.
- date  out  32  bytes 0x08..0x0B; byte 0x08 is the MSB.
- serial  out  24  bytes 0x0C..0x0E; byte 0x0C is the MSB.
- rd_addr  in  4  local byte-store index.
- rd_data  out  8  stored byte at rd_addr; combinational read; reflects store contents at any time.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FSM to IDLE; prom_s_n=1, prom_a=0.
  - busy, done, valid, fmt_err, chk_err = 0.
  - Byte store and XOR accumulator = 0, so all field outputs and rd_data read 0.
  - Reset mid-sequence aborts immediately; prom_s_n goes high asynchronously.
- State IDLE / DONE:
  - prom_s_n=1.
  - On start=1: clear accumulator, fmt_err, chk_err, done, valid; set index=0; go to SETUP. Stored bytes are overwritten as read, not cleared.
- State SETUP (1 cycle):
  - prom_a={1'b0,index}; prom_s_n=0; busy=1.
- State WAIT (WAIT_CYCLES cycles; skipped if 0):
  - prom_a and prom_s_n held.
- State CAPTURE (1 cycle):
  - prom_s_n still 0.
  - At the closing edge: store[index] <= prom_q. If index<15: acc <= acc ^ prom_q.
  - If index==15: go to CHECK. Else index+1, go to SETUP.
  - prom_s_n returns high for the SETUP cycle boundary only if implementation requires; it must be low throughout SETUP..CAPTURE of each byte.
- Per-byte cost: WAIT_CYCLES+2 clocks. Addresses 0x10..0x1F are never driven.
- State CHECK (1 cycle):
  - prom_s_n=1.
  - fmt_err <= (store[0]!=FORMAT_ID); chk_err <= (acc!=store[15]).
  - Then DONE: done=1, busy=0, valid=~fmt_err&~chk_err.
- Latency: start sampled at edge k → done=1 after edge k+16*(WAIT_CYCLES+2)+1.
- prom_a changes only while prom_s_n=1 or at a SETUP entry edge; never during WAIT/CAPTURE.
- start during SETUP/WAIT/CAPTURE/CHECK: ignored; no restart, no glitch on outputs.
- start in DONE: full re-read. Field outputs hold stale values until each byte is re-captured.
- X/z on prom_q is captured only if it occurs inside a capture window, which is a bench error condition.

Test Plan:
- Default contents (01 01 08 00 20 01 06 E0 1A E4 23 3B 00 0D 72 56), WAIT_CYCLES=2, start at edge k:
  - done=1 and valid=1 after edge k+65; fmt_err=chk_err=0.
  - machine_type=8'h01, eth_addr=48'h0800_2001_06E0, date=32'h1AE4_233B, serial=24'h000D72, rd_addr=4'hF → rd_data=8'h56.
- Byte 0x0F changed to 8'h57 → chk_err=1, fmt_err=0, valid=0, done=1.
- Byte 0x00 changed to 8'h02 (0x0F adjusted to 8'h55 to keep checksum good) → fmt_err=1, chk_err=0, valid=0.
- Bus protocol monitor, WAIT_CYCLES=0 and 5:
  - prom_a visits 0..15 in order, never 0x10+.
  - prom_a is stable whenever prom_s_n=0.
  - Each low window lasts WAIT_CYCLES+2 cycles.
  - done is asserted after 16*(W+2)+1 cycles.
- start pulse repeated at byte 7 → no restart, same completion cycle. start after done, with PROM model changed → new values and flags reported.
- reset_n low during WAIT of byte 9 → prom_s_n=1 and all outputs 0 immediately, without a clock. Subsequent start completes normally with valid=1.
